// File: rtl/bip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bip_pkg
// Description : Shared definitions for the BIP datapath: default widths,
//               accumulator/ALU source select encodings and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package bip_pkg;

    localparam int DEF_PC_WIDTH      = 11;
    localparam int DEF_DATA_WIDTH    = 16;
    localparam int DEF_OPERAND_WIDTH = 11;

    // Accumulator source select
    localparam logic [1:0] SELA_RAM  = 2'd0;
    localparam logic [1:0] SELA_IMM  = 2'd1;
    localparam logic [1:0] SELA_ALU  = 2'd2;
    localparam logic [1:0] SELA_HOLD = 2'd3;

    // ALU operand B select
    localparam logic SELB_RAM = 1'b0;
    localparam logic SELB_IMM = 1'b1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_RDWAIT = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

endpackage : bip_pkg
`default_nettype wire

// File: rtl/bip_alu.sv
`default_nettype none
// ============================================================================
// Module      : bip_alu
// Description : Combinational add/subtract, result modulo 2^DATA_WIDTH, no flags.
// Ports       : a, b    - operands
//               sub     - 0: a+b, 1: a-b
//               result  - sum/difference
// Revision    : 1.0 - initial release
// ============================================================================
module bip_alu #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  sub,
    output logic [DATA_WIDTH-1:0] result
);

    always_comb begin
        result = sub ? (a - b) : (a + b);
    end

endmodule : bip_alu
`default_nettype wire

// File: rtl/bip_datapath.sv
`default_nettype none
// ============================================================================
// Module      : bip_datapath
// Description : BIP processor datapath and sequencer. Executes one decoded
//               control word per instruction; RAM reads take an extra RDWAIT
//               cycle because the data RAM is synchronous.
// Ports       : clk, rst_n                - clock, async active-low reset
//               instr_valid / instr_ready - instruction handshake
//               WrPC..SelB, operand       - decoded control word + operand
//               ram_addr/wdata/we/re/rdata- data RAM interface
//               pc, acc, halted           - architectural state
// Revision    : 1.0 - initial release
// ============================================================================
module bip_datapath
    import bip_pkg::*;
#(
    parameter int PC_WIDTH      = DEF_PC_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int OPERAND_WIDTH = DEF_OPERAND_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic                     WrPC,
    input  logic                     WrAcc,
    input  logic                     Op,
    input  logic                     WrRam,
    input  logic                     RdRam,
    input  logic [1:0]               SelA,
    input  logic                     SelB,
    input  logic [OPERAND_WIDTH-1:0] operand,
    output logic [OPERAND_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    output logic                     ram_we,
    output logic                     ram_re,
    input  logic [DATA_WIDTH-1:0]    ram_rdata,
    output logic [PC_WIDTH-1:0]      pc,
    output logic [DATA_WIDTH-1:0]    acc,
    output logic                     halted
);

    state_t                  state;
    logic                    issue;
    logic [DATA_WIDTH-1:0]   imm;
    logic [DATA_WIDTH-1:0]   alu_b;
    logic [DATA_WIDTH-1:0]   alu_result;
    logic [DATA_WIDTH-1:0]   acc_next;

    // Immediate: operand sign-extended (or truncated) to the data width
    generate
        if (DATA_WIDTH > OPERAND_WIDTH) begin : g_imm_sext
            assign imm = {{(DATA_WIDTH-OPERAND_WIDTH){operand[OPERAND_WIDTH-1]}}, operand};
        end else begin : g_imm_trunc
            assign imm = operand[DATA_WIDTH-1:0];
        end
    endgenerate

    // A non-halting instruction presented in RUN. Gated by rst_n so that no
    // strobe escapes while reset is held.
    always_comb begin
        issue       = rst_n && (state == ST_RUN) && instr_valid && WrPC;
        ram_re      = issue && RdRam;
        ram_we      = issue && !RdRam && WrRam;
        instr_ready = rst_n && ((issue && !RdRam) || (state == ST_RDWAIT));
        ram_addr    = (ram_re || ram_we) ? operand : '0;
    end

    assign ram_wdata = acc;

    // In RUN with RdRam=0 the RAM-data path carries whatever ram_rdata holds;
    // it is only meaningful in RDWAIT, where it is the word just read.
    always_comb begin
        alu_b = ram_rdata;
        case (SelB)
            SELB_RAM: alu_b = ram_rdata;
            SELB_IMM: alu_b = imm;
            default:  alu_b = ram_rdata;
        endcase
    end

    bip_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .a      (acc),
        .b      (alu_b),
        .sub    (Op),
        .result (alu_result)
    );

    always_comb begin
        acc_next = acc;
        case (SelA)
            SELA_RAM:  acc_next = ram_rdata;
            SELA_IMM:  acc_next = imm;
            SELA_ALU:  acc_next = alu_result;
            SELA_HOLD: acc_next = acc;
            default:   acc_next = acc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            pc     <= '0;
            acc    <= '0;
            halted <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (instr_valid) begin
                        if (!WrPC) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end else if (RdRam) begin
                            // Address issued now; data consumed next cycle
                            state <= ST_RDWAIT;
                        end else begin
                            pc <= pc + PC_WIDTH'(1);
                            if (WrAcc) begin
                                acc <= acc_next;
                            end
                        end
                    end
                end
                ST_RDWAIT: begin
                    // Control word is still held by upstream
                    pc <= pc + PC_WIDTH'(1);
                    if (WrAcc) begin
                        acc <= acc_next;
                    end
                    state <= ST_RUN;
                end
                ST_HALT: begin
                    state  <= ST_HALT;
                    halted <= 1'b1;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule : bip_datapath
`default_nettype wire

// File: tb/tb_bip_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_bip_datapath
// Description : Self-checking bench for bip_datapath with a synchronous RAM
//               model and a reference model feeding an expected-state queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bip_datapath;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic        WrPC, WrAcc, Op, WrRam, RdRam;
    logic [1:0]  SelA;
    logic        SelB;
    logic [10:0] operand;
    logic [10:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we, ram_re;
    logic [15:0] ram_rdata;
    logic [10:0] pc;
    logic [15:0] acc;
    logic        halted;

    always #5 clk = ~clk;

    bip_datapath dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .WrPC        (WrPC),
        .WrAcc       (WrAcc),
        .Op          (Op),
        .WrRam       (WrRam),
        .RdRam       (RdRam),
        .SelA        (SelA),
        .SelB        (SelB),
        .operand     (operand),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_re      (ram_re),
        .ram_rdata   (ram_rdata),
        .pc          (pc),
        .acc         (acc),
        .halted      (halted)
    );

    // Synchronous data RAM
    logic [15:0] ram [0:2047];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= ram[ram_addr];
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [10:0] pc;
        logic [15:0] acc;
        logic        halted;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    logic [10:0] m_pc;
    logic [15:0] m_acc;
    logic        m_halted;
    logic [15:0] m_mem [int];

    // Observations from the last driven instruction
    int          obs_cyc, obs_ready, obs_re, obs_we, obs_addr_bad;
    logic [10:0] obs_addr;
    logic [15:0] obs_wdata;
    logic [10:0] obs_pc_mid;

    task automatic model_reset();
        m_pc = '0; m_acc = '0; m_halted = 1'b0;
    endtask

    task automatic idle_inputs();
        instr_valid = 1'b0; WrPC = 1'b0; WrAcc = 1'b0; Op = 1'b0;
        WrRam = 1'b0; RdRam = 1'b0; SelA = 2'd3; SelB = 1'b0; operand = '0;
    endtask

    // Drive one instruction, push the model's expected post-state, and record
    // what the DUT did on the RAM/handshake signals (at most 4 cycles).
    task automatic drive_instr(input logic wrpc, input logic wracc, input logic op,
                               input logic wrram, input logic rdram, input logic [1:0] sela,
                               input logic selb, input logic [10:0] opnd);
        logic [15:0] imm, ramv, b, alu, src;
        logic rdy;
        imm = {{5{opnd[10]}}, opnd};
        if (!m_halted) begin
            if (!wrpc) begin
                m_halted = 1'b1;
            end else begin
                ramv = m_mem.exists(int'(opnd)) ? m_mem[int'(opnd)] : 16'h0000;
                b    = selb ? imm : ramv;
                alu  = op ? (m_acc - b) : (m_acc + b);
                case (sela)
                    2'd0:    src = ramv;
                    2'd1:    src = imm;
                    2'd2:    src = alu;
                    default: src = m_acc;
                endcase
                if (wrram && !rdram) m_mem[int'(opnd)] = m_acc;
                if (wracc) m_acc = src;
                m_pc = m_pc + 11'd1;
            end
        end
        sb.push_back('{m_pc, m_acc, m_halted});

        obs_cyc = 0; obs_ready = 0; obs_re = 0; obs_we = 0; obs_addr_bad = 0;
        obs_addr = '0; obs_wdata = '0; obs_pc_mid = pc;
        WrPC = wrpc; WrAcc = wracc; Op = op; WrRam = wrram; RdRam = rdram;
        SelA = sela; SelB = selb; operand = opnd; instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            obs_cyc++;
            if (ram_re) begin obs_re++; obs_addr = ram_addr; end
            if (ram_we) begin obs_we++; obs_addr = ram_addr; obs_wdata = ram_wdata; end
            if (!ram_re && !ram_we && ram_addr != 11'd0) obs_addr_bad++;
            rdy = instr_ready;
            if (rdy) obs_ready++;
            @(posedge clk);
            #1;
            if (i == 0) obs_pc_mid = pc;
            if (rdy) break;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        idle_inputs();
        // Strobe-inducing inputs while reset is held must stay silent
        instr_valid = 1'b1; WrPC = 1'b1; RdRam = 1'b1; operand = 11'h055;
        model_reset();
        sb.push_back('{m_pc, m_acc, m_halted});
        repeat (2) @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        checks++; if (pc !== e.pc) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, e.pc); end
        checks++; if (acc !== e.acc) begin errors++; $display("FAIL reset_acc: got %h want %h", acc, e.acc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        checks++; if ({ram_re, ram_we, instr_ready} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes: re/we/ready got %b want 000", {ram_re, ram_we, instr_ready}); end
        checks++; if (ram_addr !== 11'd0) begin errors++; $display("FAIL reset_addr: got %h want 000", ram_addr); end
        @(posedge clk); #1;
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        logic [10:0] pc0;
        logic [15:0] acc0;
        int bad;
        pc0 = pc; acc0 = acc; bad = 0;
        WrPC = 1'b1; RdRam = 1'b1; WrRam = 1'b1; WrAcc = 1'b1; SelA = 2'd1; operand = 11'h3A5;
        instr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ram_re || ram_we || instr_ready || ram_addr != 11'd0) bad++;
        end
        @(posedge clk); #1;
        checks++; if (bad !== 0) begin errors++; $display("FAIL idle_strobes: got %0d active cycles want 0", bad); end
        checks++; if (pc !== pc0 || acc !== acc0) begin
            errors++; $display("FAIL idle_hold: pc/acc got %h/%h want %h/%h", pc, acc, pc0, acc0); end
        idle_inputs();
    endtask

    task automatic test_ldi();
        exp_t e;
        drive_instr(1, 1, 0, 0, 0, 2'd1, 0, 11'd5);
        e = sb.pop_front();
        checks++; if (acc !== 16'd5 || acc !== e.acc) begin errors++; $display("FAIL ldi_acc: got %h want %h", acc, e.acc); end
        checks++; if (pc !== 11'd1 || pc !== e.pc) begin errors++; $display("FAIL ldi_pc: got %h want %h", pc, e.pc); end
        checks++; if (obs_ready !== 1 || obs_cyc !== 1) begin
            errors++; $display("FAIL ldi_ready: ready cycles %0d in %0d want 1 in 1", obs_ready, obs_cyc); end
        checks++; if (obs_re !== 0 || obs_we !== 0 || obs_addr_bad !== 0) begin
            errors++; $display("FAIL ldi_strobes: re %0d we %0d badaddr %0d want 0", obs_re, obs_we, obs_addr_bad); end
    endtask

    task automatic test_alu_imm();
        exp_t e;
        drive_instr(1, 1, 0, 0, 0, 2'd2, 1, 11'h7FD);   // ADDI -3
        e = sb.pop_front();
        checks++; if (acc !== 16'd2 || acc !== e.acc) begin errors++; $display("FAIL addi_acc: got %h want %h", acc, e.acc); end
        drive_instr(1, 1, 0, 0, 0, 2'd1, 0, 11'd0);     // LDI 0
        e = sb.pop_front();
        drive_instr(1, 1, 1, 0, 0, 2'd2, 1, 11'd3);     // SUBI 3
        e = sb.pop_front();
        checks++; if (acc !== 16'hFFFD || acc !== e.acc) begin errors++; $display("FAIL subi_acc: got %h want %h", acc, e.acc); end
        checks++; if (pc !== e.pc) begin errors++; $display("FAIL alu_pc: got %h want %h", pc, e.pc); end
    endtask

    task automatic test_store_load();
        exp_t e;
        logic [10:0] pc_before;
        // Build 0x1234 = 4*1023 + 568
        drive_instr(1, 1, 0, 0, 0, 2'd1, 0, 11'h3FF); e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            drive_instr(1, 1, 0, 0, 0, 2'd2, 1, 11'h3FF); e = sb.pop_front();
        end
        drive_instr(1, 1, 0, 0, 0, 2'd2, 1, 11'h238); e = sb.pop_front();
        checks++; if (acc !== 16'h1234 || acc !== e.acc) begin errors++; $display("FAIL build_acc: got %h want %h", acc, e.acc); end

        drive_instr(1, 0, 0, 1, 0, 2'd3, 0, 11'h010);   // STO 0x10
        e = sb.pop_front();
        checks++; if (obs_we !== 1 || obs_re !== 0 || obs_cyc !== 1) begin
            errors++; $display("FAIL sto_pulse: we %0d re %0d cycles %0d want 1 0 1", obs_we, obs_re, obs_cyc); end
        checks++; if (obs_addr !== 11'h010 || obs_wdata !== 16'h1234) begin
            errors++; $display("FAIL sto_bus: addr %h data %h want 010 1234", obs_addr, obs_wdata); end
        checks++; if (pc !== e.pc || acc !== e.acc) begin errors++; $display("FAIL sto_state: pc/acc %h/%h want %h/%h", pc, acc, e.pc, e.acc); end

        drive_instr(1, 1, 0, 0, 0, 2'd1, 0, 11'd0); e = sb.pop_front();   // LDI 0
        pc_before = pc;
        drive_instr(1, 1, 0, 0, 1, 2'd0, 0, 11'h010);   // LD 0x10
        e = sb.pop_front();
        checks++; if (obs_re !== 1 || obs_we !== 0 || obs_addr !== 11'h010) begin
            errors++; $display("FAIL ld_pulse: re %0d we %0d addr %h want 1 0 010", obs_re, obs_we, obs_addr); end
        checks++; if (obs_cyc !== 2 || obs_ready !== 1) begin
            errors++; $display("FAIL ld_latency: cycles %0d ready %0d want 2 1", obs_cyc, obs_ready); end
        checks++; if (obs_pc_mid !== pc_before) begin errors++; $display("FAIL ld_pc_mid: got %h want %h", obs_pc_mid, pc_before); end
        checks++; if (acc !== 16'h1234 || acc !== e.acc || pc !== e.pc) begin
            errors++; $display("FAIL ld_state: pc/acc %h/%h want %h/%h", pc, acc, e.pc, e.acc); end

        // Store and load-immediate together: stored word is the old accumulator
        drive_instr(1, 1, 0, 1, 0, 2'd1, 0, 11'h011);
        e = sb.pop_front();
        checks++; if (obs_wdata !== 16'h1234 || obs_addr !== 11'h011 || obs_we !== 1) begin
            errors++; $display("FAIL sto_preupdate: data %h addr %h we %0d want 1234 011 1", obs_wdata, obs_addr, obs_we); end
        checks++; if (acc !== e.acc) begin errors++; $display("FAIL sto_ldi_acc: got %h want %h", acc, e.acc); end
    endtask

    task automatic test_ram_alu();
        exp_t e;
        drive_instr(1, 1, 0, 1, 1, 2'd2, 0, 11'h010);   // ADD [0x10], WrRam ignored
        e = sb.pop_front();
        checks++; if (obs_we !== 0 || obs_re !== 1) begin errors++; $display("FAIL rd_ignores_wr: we %0d re %0d want 0 1", obs_we, obs_re); end
        checks++; if (acc !== e.acc) begin errors++; $display("FAIL add_ram_acc: got %h want %h", acc, e.acc); end
        drive_instr(1, 1, 1, 0, 1, 2'd2, 0, 11'h011);   // SUB [0x11]
        e = sb.pop_front();
        checks++; if (acc !== e.acc || pc !== e.pc) begin errors++; $display("FAIL sub_ram: pc/acc %h/%h want %h/%h", pc, acc, e.pc, e.acc); end
        drive_instr(1, 1, 0, 0, 0, 2'd3, 1, 11'h155);   // SelA hold with WrAcc
        e = sb.pop_front();
        checks++; if (acc !== e.acc || pc !== e.pc) begin errors++; $display("FAIL sela_hold: pc/acc %h/%h want %h/%h", pc, acc, e.pc, e.acc); end
    endtask

    task automatic test_pc_wrap();
        exp_t e;
        while (m_pc != 11'h7FF) begin
            drive_instr(1, 0, 0, 0, 0, 2'd3, 0, 11'd0);
            e = sb.pop_front();
        end
        checks++; if (pc !== 11'h7FF) begin errors++; $display("FAIL pc_top: got %h want 7ff", pc); end
        drive_instr(1, 1, 0, 0, 0, 2'd2, 1, 11'd1);     // ADDI 1
        e = sb.pop_front();
        checks++; if (pc !== 11'h000 || pc !== e.pc) begin errors++; $display("FAIL pc_wrap: got %h want 000", pc); end
        checks++; if (acc !== e.acc) begin errors++; $display("FAIL wrap_acc: got %h want %h", acc, e.acc); end
    endtask

    task automatic test_halt();
        exp_t e;
        drive_instr(0, 0, 0, 0, 0, 2'd3, 0, 11'd0);     // HLT
        e = sb.pop_front();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b want 1", halted); end
        checks++; if (pc !== e.pc || acc !== e.acc) begin errors++; $display("FAIL halt_state: pc/acc %h/%h want %h/%h", pc, acc, e.pc, e.acc); end
        checks++; if (obs_ready !== 0 || obs_re !== 0 || obs_we !== 0) begin
            errors++; $display("FAIL halt_strobes: ready %0d re %0d we %0d want 0", obs_ready, obs_re, obs_we); end
        drive_instr(1, 1, 0, 1, 0, 2'd1, 0, 11'd7);     // ignored
        e = sb.pop_front();
        checks++; if (pc !== e.pc || acc !== e.acc || halted !== 1'b1) begin
            errors++; $display("FAIL halt_sticky: pc/acc/h %h/%h/%b want %h/%h/1", pc, acc, halted, e.pc, e.acc); end
        checks++; if (obs_ready !== 0 || obs_we !== 0) begin errors++; $display("FAIL halt_ignore: ready %0d we %0d want 0", obs_ready, obs_we); end
        rst_n = 1'b0;
        #2;
        model_reset();
        checks++; if (pc !== 11'd0 || acc !== 16'd0 || halted !== 1'b0) begin
            errors++; $display("FAIL halt_reset: pc/acc/h %h/%h/%b want 000/0000/0", pc, acc, halted); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset_rdwait();
        exp_t e;
        // acc=0, pc=0 here; LD 0x10 would bring in 0x1234
        WrPC = 1'b1; WrAcc = 1'b1; RdRam = 1'b1; SelA = 2'd0; operand = 11'h010; instr_valid = 1'b1;
        @(negedge clk);
        checks++; if (ram_re !== 1'b1) begin errors++; $display("FAIL rdw_issue: re got %b want 1", ram_re); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rdw_ready: got %b want 1", instr_ready); end
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (acc !== 16'd0 || pc !== 11'd0) begin
            errors++; $display("FAIL rdw_abort: pc/acc %h/%h want 000/0000", pc, acc); end
        idle_inputs();
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        checks++; if (instr_ready !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL rdw_run: ready/halted %b/%b want 0/0", instr_ready, halted); end
        @(posedge clk); #1;
        drive_instr(1, 1, 0, 0, 0, 2'd1, 0, 11'd9);     // LDI 9 completes in one cycle
        e = sb.pop_front();
        checks++; if (obs_cyc !== 1 || acc !== e.acc || pc !== e.pc) begin
            errors++; $display("FAIL rdw_resume: cycles %0d pc/acc %h/%h want 1 %h/%h", obs_cyc, pc, acc, e.pc, e.acc); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_idle();
        test_ldi();
        test_alu_imm();
        test_store_load();
        test_ram_alu();
        test_pc_wrap();
        test_halt();
        test_reset_rdwait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bip_datapath
`default_nettype wire

// File: doc/bip_datapath.md
BIP_DATAPATH -- requirements
Module: bip_datapath

Interface
REQ-001 Parameter: PC_WIDTH, default 11, program counter width.
REQ-002 Parameter: DATA_WIDTH, default 16, accumulator and data RAM word width.
REQ-003 Parameter: OPERAND_WIDTH, default 11, instruction operand width; also the data RAM address width.
REQ-004 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 Port: instr_valid  input  1  decoded control word and operand are valid.
REQ-007 Port: instr_ready  output  1  the current instruction completes this cycle.
REQ-008 Port: WrPC, WrAcc, Op, WrRam, RdRam  input  1 each  decoder control bits.
REQ-009 Port: SelA  input  2  accumulator source select: 0 RAM data, 1 immediate, 2 ALU, 3 hold.
REQ-010 Port: SelB  input  1  ALU operand B select: 0 RAM data, 1 immediate.
REQ-011 Port: operand  input  OPERAND_WIDTH  immediate value or RAM address.
REQ-012 Port: ram_addr  output  OPERAND_WIDTH  data RAM address.
REQ-013 Port: ram_wdata  output  DATA_WIDTH  RAM write data, equal to acc.
REQ-014 Port: ram_we / ram_re  output  1 each  RAM write / read strobes.
REQ-015 Port: ram_rdata  input  DATA_WIDTH  RAM read data, valid one cycle after a ram_re cycle (synchronous RAM).
REQ-016 Port: pc  output  PC_WIDTH  registered program counter.
REQ-017 Port: acc  output  DATA_WIDTH  registered accumulator.
REQ-018 Port: halted  output  1  high while in HALT.

Function
REQ-019 States: RUN, RDWAIT, HALT.
REQ-020 An instruction is consumed on every cycle where instr_valid and instr_ready are both high.
REQ-021 RUN with instr_valid=0: no RAM strobes, instr_ready=0, pc and acc hold.
REQ-022 RUN with instr_valid=1 and WrPC=0: next state HALT; instr_ready=0; no strobes; pc and acc hold.
REQ-023 RUN with instr_valid=1, WrPC=1, RdRam=1: ram_re=1 and ram_addr=operand in that cycle; instr_ready=0; next state RDWAIT.
REQ-024 RUN with instr_valid=1, WrPC=1, RdRam=0: instr_ready=1; pc increments; if WrRam, then ram_we=1 with ram_addr=operand and ram_wdata=acc (the pre-update value); if WrAcc, acc loads the SelA source.
REQ-025 RDWAIT: ram_re=0 and instr_ready=1; acc loads the SelA source using ram_rdata when WrAcc; pc increments; next state RUN.
REQ-026 Upstream holds the control word and operand stable until the instruction is consumed; in RDWAIT the block reuses the held values.
REQ-027 Immediate is operand sign-extended to DATA_WIDTH.
REQ-028 ALU result is acc+B when Op=0 and acc-B when Op=1, computed modulo 2^DATA_WIDTH with no flags.
REQ-029 When RdRam=1, WrRam is ignored and no write occurs.
REQ-030 SelA=3 with WrAcc=1 leaves acc unchanged.
REQ-031 pc wraps from 2^PC_WIDTH-1 to 0.
REQ-032 HALT is sticky until reset: no strobes, instr_ready=0, halted=1, instr_valid ignored.
REQ-033 ram_addr, ram_we, ram_re and instr_ready are combinational from state and inputs; ram_addr=0 when no strobe is active.

Reset
REQ-034 While rst_n=0: state=RUN, pc=0, acc=0, halted=0, all strobes 0.
REQ-035 Reset asserted in RDWAIT or HALT aborts the operation with no acc or pc update; execution resumes in RUN on the first edge after release.

Structure
REQ-036 Package bip_pkg holds the SelA/SelB encodings, state encoding, and default widths.
REQ-037 One sub-module, bip_alu, provides combinational add/subtract of width DATA_WIDTH.

Verification
REQ-038 LDI 5 (SelA=1, WrAcc=1, operand=5) from reset -> acc=5, pc=1 after one edge, instr_ready high for one cycle.
REQ-039 ADDI -3 with acc=5 (operand=0x7FD, Op=0, SelA=2, SelB=1) -> acc=2; SUBI 3 with acc=0 -> acc=0xFFFD.
REQ-040 STO 0x10 with acc=0x1234 -> ram_we=1, ram_addr=0x10, ram_wdata=0x1234 for exactly one cycle; then LD 0x10 -> ram_re for one cycle, RDWAIT one cycle, acc=0x1234, pc advanced by 1 only after RDWAIT.
REQ-041 pc=0x7FF plus any non-halting instruction -> pc=0x000.
REQ-042 HLT (WrPC=0) -> halted=1, pc frozen; further instr_valid pulses produce no change; rst_n pulse low -> pc=0, acc=0, halted=0.
REQ-043 rst_n asserted during RDWAIT of an LD -> acc stays 0, pc=0, state RUN after release.
